idex_pipe_buffer: RTL
=====================

# idex_pipe_buffer

Parametrised ID/EX pipeline buffer between the decode and execute stages of the 32-bit MIPS pipeline. It carries a control bundle and a data bundle through a two-entry skid buffer with valid/ready handshaking, synchronous flush and NOP-bubble insertion. Upstream stalls therefore never corrupt in-flight instructions, and a stalled execute stage does not create a combinational ready path back into decode.

## Interface
Parameters:
- `CTRL_W`, default 10: control bundle width (WB 2 + M 3 + EX 5). Zeroed on every bubble.
- `DATA_W`, default 165: data bundle width (next address, operand 1, operand 2, extended immediate, RT, RD, jump flag, J-field).
- `CNT_W`, default 16: width of the stall counter.

Ports (name, direction, width, meaning):
- `clk`: input, 1. Rising-edge clock.
- `rst`: input, 1. Synchronous, active-high reset.
- `flush`: input, 1. Synchronous squash of all held entries (branch/jump taken).
- `in_valid`: input, 1. Decode presents an instruction.
- `in_ready`: output, 1. Buffer can accept; registered.
- `in_ctrl`: input, CTRL_W. Control bundle from decode.
- `in_data`: input, DATA_W. Data bundle from decode.
- `out_valid`: output, 1. Execute-side entry valid.
- `out_ready`: input, 1. Execute consumes the entry this cycle.
- `out_ctrl`: output, CTRL_W. Control to execute; forced to all-zero while `out_valid`=0.
- `out_data`: output, DATA_W. Data to execute; unspecified while `out_valid`=0.
- `occupancy`: output, 2. Held entries, 0..2.
- `stall_cnt`: output, CNT_W. Present only with `IDEX_PIPE_BUFFER_STATS_EN`.

## Operation
- Storage: main register (drives outputs) plus skid register, each with its own valid bit.
- Handshakes:
  - in_fire = `in_valid` & `in_ready`.
  - out_fire = `out_valid` & `out_ready`.
- States: EMPTY (occupancy 0), ONE (main valid), FULL (main and skid valid).
- Transitions when `flush`=0:
  - EMPTY: on in_fire, main <= in, go to ONE.
  - ONE: in_fire & out_fire → main <= in, stay in ONE.
  - ONE: in_fire only → skid <= in, go to FULL.
  - ONE: out_fire only → go to EMPTY.
  - ONE: neither → hold.
  - FULL: `in_ready`=0, so in_fire is impossible. On out_fire, main <= skid, go to ONE. Otherwise hold.
- `in_ready` = !skid_valid, registered.
- Ordering is strictly FIFO. No entry is dropped or duplicated.
- `flush`=1:
  - Next state is EMPTY.
  - Main and skid ctrl are zeroed; data is held.
  - An in_fire in the same cycle is discarded.
  - An out_fire in the same cycle still counts as consumed by execute.
- Priority: `rst` > `flush` > handshake.
- `rst`=1: valids 0, ctrl 0, data 0, `in_ready`=1 on the next cycle, `occupancy`=0, `stall_cnt`=0. Reset mid-transfer discards all held entries.
- Bubble rule: whenever `out_valid`=0, `out_ctrl` is 0. This makes execute see a NOP: no RegWrite, no MemWrite, no branch.

## Timing
- Latency: in_fire at edge N gives `out_valid`=1 with that payload after edge N, i.e. 1 cycle.
- Throughput: 1 instruction/cycle while `out_ready`=1.
- `in_ready` falls the cycle after FULL is entered and rises the cycle after the FULL→ONE out_fire. There is no combinational path from `out_ready` to `in_ready`.
- All outputs come from flops, except the `out_ctrl` bubble mask (AND of the register with `out_valid`).
- `occupancy` updates on the same edge as the state.

## Configuration
- `IDEX_PIPE_BUFFER_STATS_EN` defined:
  - `stall_cnt` port exists.
  - Increments every cycle with `out_valid`=1 & `out_ready`=0.
  - Saturates at 2^CNT_W−1.
  - Cleared only by `rst`; `flush` does not clear it.
- Not defined: the port and counter logic are absent. All other behaviour is identical.

## Test plan
- Reset, then stream: `rst`=1 for 2 cycles, then `in_valid`=1 with ctrl 0x3FF, data 1,2,3; `out_ready`=1 → out_data 1,2,3 on consecutive cycles, each 1 cycle after acceptance; `occupancy` stays at 1; `in_ready` stays 1.
- Back-pressure: `out_ready`=0 while pushing 0xA, 0xB, 0xC → 0xA and 0xB accepted, `occupancy`=2, `in_ready`=0, 0xC held upstream; then `out_ready`=1 → outputs 0xA, 0xB, 0xC in order, no loss.
- Flush while FULL: two entries held, `flush`=1 with `in_valid`=1 → next cycle `out_valid`=0, `out_ctrl`=0, `occupancy`=0, `in_ready`=1; the flushed-cycle input never appears.
- Simultaneous in/out in ONE: ctrl 0x155 held, push ctrl 0x2AA with `out_ready`=1 → 0x155 consumed and `out_ctrl`=0x2AA next cycle, `occupancy` stays 1.
- Reset mid-stall: FULL state, `rst`=1 for one cycle → `out_valid`=0, `out_ctrl`=0, `in_ready`=1, `occupancy`=0 after that edge.
- Stats (with macro): hold `out_valid`=1, `out_ready`=0 for 5 cycles → `stall_cnt`=5. With `CNT_W`=2 and 10 stall cycles → `stall_cnt`=3 (saturated). After `flush`, the count is unchanged.

Source files
------------

// File: rtl/idex_pipe_buffer.sv
// idex_pipe_buffer: ID/EX two-entry skid buffer with valid/ready handshake, flush and NOP bubbles
//
// Ports:
//   clk, rst               rising-edge clock, synchronous active-high reset
//   flush                  squash all held entries (ctrl zeroed, data held)
//   in_valid/in_ready      decode-side handshake; in_ready is registered
//   in_ctrl/in_data        control and data bundles from decode
//   out_valid/out_ready    execute-side handshake
//   out_ctrl/out_data      bundles to execute; out_ctrl is zero while out_valid=0
//   occupancy              number of held entries, 0..2
//   stall_cnt              saturating count of cycles with out_valid & !out_ready,
//                          present only when IDEX_PIPE_BUFFER_STATS_EN is defined
module idex_pipe_buffer #(
    parameter int CTRL_W = 10,
    parameter int DATA_W = 165,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
`ifdef IDEX_PIPE_BUFFER_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_e;

    state_e            state_q, state_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic              main_vld_q;
    // in_ready_q is the registered inverse of the skid valid bit
    logic              in_ready_q;
    logic              in_fire, out_fire;

    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = main_vld_q & out_ready;
    assign in_ready  = in_ready_q;
    assign out_valid = main_vld_q;
    assign out_data  = main_data_q;
    // Bubble mask: execute sees a NOP whenever the main entry is empty
    assign out_ctrl  = main_ctrl_q & {CTRL_W{main_vld_q}};
    assign occupancy = state_q;

    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            state_d     = EMPTY;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                        state_d     = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end else if (in_fire) begin
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                        state_d     = FULL;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                        state_d     = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            main_vld_q  <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            main_vld_q  <= state_d != EMPTY;
            in_ready_q  <= state_d != FULL;
        end
    end

`ifdef IDEX_PIPE_BUFFER_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q;

    assign stall_cnt = stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt_q <= '0;
        else if (main_vld_q && !out_ready && stall_cnt_q != {CNT_W{1'b1}})
            stall_cnt_q <= stall_cnt_q + 1'b1;
    end
`else
    logic [CNT_W-1:0] unused_stats;

    assign unused_stats = '0;
`endif
endmodule
